mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and memory strobes for mem_arbiter; the shared data bus stays a separate inout.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rdata, a_rvalid,
    output b_gnt, b_rdata, b_rvalid,
    output mem_rd, mem_wr, mem_addr
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rdata, a_rvalid,
    input  b_gnt, b_rdata, b_rvalid,
    input  mem_rd, mem_wr, mem_addr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one shared-bus memory: writes take 2 cycles, reads 3.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port A has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  inout  wire  [DATA_W-1:0] mem_data
);

  // state | meaning
  // IDLE  | arbitrate; strobes low, bus released
  // WR    | grant pulse, mem_wr high, latched wdata on the bus
  // RD    | grant pulse, mem_rd high, bus released
  // RCAP  | memory drives the bus; capture into the winner's rdata
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RCAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              w_any;
  logic              w_pick_b;
  logic              w_pick_we;
  logic              w_accept;
  logic              w_busy;

`ifdef MEM_ARB_RR_EN
  logic              r_last_b;
`endif

  always_comb begin
    w_any     = bus.a_req | bus.b_req;
`ifdef MEM_ARB_RR_EN
    w_pick_b  = bus.b_req & (~bus.a_req | ~r_last_b);
`else
    w_pick_b  = bus.b_req & ~bus.a_req;
`endif
    w_pick_we = w_pick_b ? bus.b_we : bus.a_we;
    w_accept  = (r_state == S_IDLE) & w_any;
    w_next    = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_pick_we ? S_WR : S_RD;
      S_WR:    w_next = S_IDLE;
      S_RD:    w_next = S_RCAP;
      S_RCAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id    <= w_pick_b;
      r_addr  <= w_pick_b ? bus.b_addr  : bus.a_addr;
      r_wdata <= w_pick_b ? bus.b_wdata : bus.a_wdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset leaves B as last winner so A takes the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_b <= 1'b1;
    else if (w_accept) r_last_b <= w_pick_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (r_state == S_RCAP) begin
        if (r_id) begin
          r_b_rdata  <= mem_data;
          r_b_rvalid <= 1'b1;
        end else begin
          r_a_rdata  <= mem_data;
          r_a_rvalid <= 1'b1;
        end
      end
    end
  end

  assign w_busy       = (r_state == S_WR) | (r_state == S_RD);
  assign bus.a_gnt    = w_busy & ~r_id;
  assign bus.b_gnt    = w_busy & r_id;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rdata  = r_b_rdata;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.mem_rd   = (r_state == S_RD);
  assign bus.mem_wr   = (r_state == S_WR);
  assign bus.mem_addr = r_addr;

  // Only WR drives the bus, so it can never overlap the memory's RCAP drive.
  assign mem_data = (r_state == S_WR) ? r_wdata : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-indexed expectation model, shared-memory model and directed scenarios.
module tb_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  logic rst_n;
  wire [DW-1:0] mem_data;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Shared memory: drives the bus in the cycle after mem_rd, stores on mem_wr.
  logic [DW-1:0] mem [256];
  logic          mem_oe;
  logic [AW-1:0] mem_oaddr;
  assign mem_data = mem_oe ? mem[mem_oaddr] : 'z;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 8'h3C;
    mem_oe    <= 1'b0;
    mem_oaddr <= '0;
    forever begin
      @(posedge clk);
      mem_oe    <= bus.mem_rd;
      mem_oaddr <= bus.mem_addr;
      if (bus.mem_wr) mem[bus.mem_addr] <= mem_data;
    end
  end

  // Expected outputs indexed by cycle number.
  bit            e_agnt [NCYC];
  bit            e_bgnt [NCYC];
  bit            e_rd   [NCYC];
  bit            e_wr   [NCYC];
  bit            e_arv  [NCYC];
  bit            e_brv  [NCYC];
  logic [AW-1:0] e_addr [NCYC];
  logic [DW-1:0] e_wdata[NCYC];
  logic [DW-1:0] e_rdata[NCYC];
  logic [DW-1:0] m_mem  [256];

  initial begin
    int            free;
    int            c;
    bit            last_b;
    bit            win_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    free   = 0;
    last_b = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = DW'(i) ^ 8'h3C;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      c   = cyc;
      if (!rst_n) begin
        for (int k = c; k < NCYC; k++) begin
          e_agnt[k] = 0; e_bgnt[k] = 0; e_rd[k] = 0; e_wr[k] = 0;
          e_arv[k]  = 0; e_brv[k]  = 0;
        end
        free   = c;
        last_b = 1'b1;
      end else if ((c - 1 >= free) && (bus.a_req || bus.b_req) && (c + 2 < NCYC)) begin
        if (bus.a_req && bus.b_req) begin
`ifdef MEM_ARB_RR_EN
          win_b = !last_b;
`else
          win_b = 1'b0;
`endif
        end else begin
          win_b = bus.b_req;
        end
        we   = win_b ? bus.b_we    : bus.a_we;
        addr = win_b ? bus.b_addr  : bus.a_addr;
        wd   = win_b ? bus.b_wdata : bus.a_wdata;
        if (win_b) e_bgnt[c] = 1; else e_agnt[c] = 1;
        e_addr[c] = addr;
        if (we) begin
          e_wr[c]    = 1;
          e_wdata[c] = wd;
          m_mem[addr] = wd;
          free = c + 1;
        end else begin
          e_rd[c] = 1;
          if (win_b) e_brv[c + 2] = 1; else e_arv[c + 2] = 1;
          e_rdata[c + 2] = m_mem[addr];
          free = c + 2;
        end
        last_b = win_b;
      end
    end
  end

  initial begin
    int c;
    forever begin
      @(negedge clk);
      c = cyc;
      if (!rst_n) begin
        chk("rst_a_gnt", bus.a_gnt, 0);
        chk("rst_b_gnt", bus.b_gnt, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_b_rvalid", bus.b_rvalid, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
      end else begin
        chk("a_gnt", bus.a_gnt, e_agnt[c]);
        chk("b_gnt", bus.b_gnt, e_bgnt[c]);
        chk("mem_rd", bus.mem_rd, e_rd[c]);
        chk("mem_wr", bus.mem_wr, e_wr[c]);
        chk("a_rvalid", bus.a_rvalid, e_arv[c]);
        chk("b_rvalid", bus.b_rvalid, e_brv[c]);
        if (e_rd[c] || e_wr[c]) chk("mem_addr", bus.mem_addr, e_addr[c]);
        if (e_wr[c]) chk("mem_data_wr", mem_data, e_wdata[c]);
        if (e_arv[c]) chk("a_rdata", bus.a_rdata, e_rdata[c]);
        if (e_brv[c]) chk("b_rdata", bus.b_rdata, e_rdata[c]);
        if (bus.a_gnt) glog.push_back(0);
        if (bus.b_gnt) glog.push_back(1);
      end
      if (mem_oe) begin
        chk("no_wr_while_mem_drives", bus.mem_wr, 0);
        chk("bus_value_mem_drive", mem_data, mem[mem_oaddr]);
      end
    end
  end

  task automatic clear_inputs;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  // Holds a request until its grant is seen, then drops it after that edge.
  task automatic drive_req(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
    bit seen;
    seen = 0;
    if (port) begin
      bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = port ? bus.b_gnt : bus.a_gnt;
    end
    chk("grant_within_budget", seen, 1);
    @(posedge clk); #1;
    if (port) bus.b_req = 0; else bus.a_req = 0;
  endtask

  typedef struct {
    bit            a_en; bit a_we; logic [AW-1:0] a_addr; logic [DW-1:0] a_wd;
    bit            b_en; bit b_we; logic [AW-1:0] b_addr; logic [DW-1:0] b_wd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nb;
    vecs[0] = '{1, 1, 8'h40, 8'h11, 1, 1, 8'h41, 8'h22};
    vecs[1] = '{1, 0, 8'h41, 8'h00, 1, 0, 8'h40, 8'h00};
    vecs[2] = '{1, 0, 8'hFF, 8'h00, 1, 1, 8'h40, 8'h33};
    vecs[3] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00};

    rst_n = 0;
    clear_inputs();
    repeat (3) @(posedge clk); #1;

    // Release reset with a write already pending on A.
    rst_n = 1;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h10; bus.a_wdata = 8'hA5;
    @(posedge clk); @(negedge clk);
    chk("wr_a_gnt", bus.a_gnt, 1);
    chk("wr_mem_wr", bus.mem_wr, 1);
    chk("wr_mem_addr", bus.mem_addr, 8'h10);
    chk("wr_mem_data", mem_data, 8'hA5);
    @(posedge clk); #1;
    bus.a_req = 0;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'h10;
    @(posedge clk); @(negedge clk);
    chk("rd_b_gnt", bus.b_gnt, 1);
    chk("rd_mem_rd", bus.mem_rd, 1);
    chk("rd_a_gnt_low", bus.a_gnt, 0);
    @(posedge clk); #1;
    bus.b_req = 0;
    @(posedge clk); @(negedge clk);
    chk("rd_b_rvalid", bus.b_rvalid, 1);
    chk("rd_b_rdata", bus.b_rdata, 8'hA5);
    chk("rd_a_rvalid_low", bus.a_rvalid, 0);

    // Read 0x20 then write 0xFF with req held across the grant.
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h20;
    @(posedge clk); @(negedge clk);
    chk("b2b_rd_gnt", bus.a_gnt, 1);
    chk("b2b_mem_rd", bus.mem_rd, 1);
    @(posedge clk); #1;
    bus.a_we = 1; bus.a_addr = 8'hFF; bus.a_wdata = 8'h5C;
    @(negedge clk);
    chk("b2b_rcap_no_wr", bus.mem_wr, 0);
    chk("b2b_rcap_bus", mem_data, 8'h1C);
    @(posedge clk); @(negedge clk);
    chk("b2b_rvalid", bus.a_rvalid, 1);
    chk("b2b_rdata", bus.a_rdata, 8'h1C);
    chk("b2b_idle_no_wr", bus.mem_wr, 0);
    @(posedge clk); @(negedge clk);
    chk("b2b_wr_gnt", bus.a_gnt, 1);
    chk("b2b_wr_strobe", bus.mem_wr, 1);
    chk("b2b_wr_addr", bus.mem_addr, 8'hFF);
    chk("b2b_wr_data", mem_data, 8'h5C);
    @(posedge clk); #1;
    bus.a_req = 0;

    // Reset asserted while the read is in RCAP.
    @(posedge clk); #1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h10;
    @(posedge clk); @(negedge clk);
    chk("rcap_rd_gnt", bus.a_gnt, 1);
    @(posedge clk); #1;
    bus.a_req = 0;
    #1 rst_n = 0;
    @(negedge clk);
    chk("rcap_rst_rvalid", bus.a_rvalid, 0);
    @(posedge clk); @(negedge clk);
    chk("rcap_rst_rvalid_after", bus.a_rvalid, 0);
    chk("rcap_rst_rdata", bus.a_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h10;
    @(posedge clk); @(negedge clk);
    chk("post_rst_gnt", bus.a_gnt, 1);
    chk("post_rst_mem_rd", bus.mem_rd, 1);
    @(posedge clk); #1;
    bus.a_req = 0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_rvalid", bus.a_rvalid, 1);
    chk("post_rst_rdata", bus.a_rdata, 8'hA5);
    @(posedge clk); #1;

    // Mixed concurrent vectors, checked by the model.
    foreach (vecs[i]) begin
      fork
        if (vecs[i].a_en) drive_req(0, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd);
        if (vecs[i].b_en) drive_req(1, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd);
      join
      repeat (4) @(posedge clk); #1;
    end

    // Both ports reading continuously from reset.
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    glog.delete();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h10;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'h30;
    repeat (24) @(posedge clk); #1;
    clear_inputs();
    repeat (4) @(posedge clk); #1;
    chk("contend_grant_count", glog.size() >= 4, 1);
    nb = 0;
    foreach (glog[i]) if (glog[i] == 1) nb++;
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) begin
`ifdef MEM_ARB_RR_EN
        chk("contend_rr_order", glog[i], i % 2);
`else
        chk("contend_fixed_order", glog[i], 0);
`endif
      end
    end
`ifndef MEM_ARB_RR_EN
    chk("contend_b_never", nb, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
